apb2_master_bridge: RTL and testbench
=====================================

// Module: apb2_master_bridge
// PURPOSE
//  APB2 requester: turns one-at-a-time register commands (valid/ready) into APB setup/access
//  phases and returns read data/status on a response channel (valid/ready).
//  Drives the BLDC peripheral bus from the soft-CPU/UART command side; peer of the APB completers.
//  Single outstanding transfer; no reordering.
// PARAMETERS
//  data_width      32   APB data width (multiple of 8)
//  addr_width      8    APB address width; register space is word-addressed (byte addr, 4-aligned)
//  timeout_cycles  256  max ACCESS cycles before abort (used only with APB_TIMEOUT_EN)
// PORTS
//  pclk        in   1              bus clock, all logic rising-edge
//  preset      in   1              synchronous reset, active-high
//  cmd_valid   in   1              command offered
//  cmd_ready   out  1              command accepted when cmd_valid && cmd_ready
//  cmd_write   in   1              1 = write, 0 = read
//  cmd_addr    in   addr_width     byte address
//  cmd_wdata   in   data_width     write data
//  cmd_strb    in   data_width/8   write byte strobes (forced 0 on reads)
//  rsp_valid   out  1              response available
//  rsp_ready   in   1              response consumed when rsp_valid && rsp_ready
//  rsp_rdata   out  data_width     read data (0 for writes/errors)
//  rsp_err     out  1              pslverr, misalignment or timeout
//  rsp_timeout out  1              error caused by timeout (always 0 without APB_TIMEOUT_EN)
//  psel, penable, pwrite  out 1    APB control
//  paddr       out  addr_width     APB address
//  pwdata      out  data_width     APB write data
//  pstrb       out  data_width/8   APB strobes
//  pprot       out  3              fixed 3'b000
//  prdata      in   data_width     APB read data (may be 'z outside access; sample only on pready)
//  pready      in   1              completer ready
//  pslverr     in   1              completer error, valid with pready
// BEHAVIOUR
//  Reset (sync, preset=1): state IDLE; psel=penable=pwrite=0; paddr/pwdata/pstrb=0; cmd_ready=0
//   during reset, 1 the first cycle after; rsp_valid=0; rsp_rdata=0; rsp_err=rsp_timeout=0.
//  States: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//   IDLE: cmd_ready=1. On handshake, register cmd into paddr/pwrite/pwdata/pstrb -> SETUP.
//     If cmd_addr[1:0]!=0: no bus cycle, go to RESP with rsp_err=1, rsp_rdata=0.
//   SETUP (1 cycle): psel=1, penable=0 -> ACCESS.
//   ACCESS: psel=1, penable=1, all address/data outputs stable; wait any number of cycles.
//     On pready=1: capture prdata (reads only, else 0) and pslverr into rsp_*; drop psel/penable
//     next edge -> RESP.
//   RESP: rsp_valid=1, held with stable data until rsp_ready=1 -> IDLE. No new bus cycle meanwhile.
//  cmd_ready=0 in SETUP/ACCESS/RESP; back-to-back commands therefore cost >= 4 cycles each.
//  Min latency: handshake at cycle 0, SETUP 1, ACCESS 2, rsp_valid at cycle 3 if pready at 2.
//  rsp_ready high in the same cycle rsp_valid rises completes the response in that cycle.
//  pready/pslverr/prdata ignored outside ACCESS.
//  Reset mid-transfer: psel/penable drop at the reset edge; in-flight cmd and response discarded.
// CONFIGURATION
//  APB_TIMEOUT_EN defined: ACCESS cycle counter (clog2(timeout_cycles+1) bits, cleared on SETUP
//   entry); when timeout_cycles ACCESS cycles elapse with no pready, abort: drop psel/penable,
//   rsp_err=1, rsp_timeout=1, rsp_rdata=0 -> RESP. A pready on the same cycle as expiry wins.
//  Not defined: no counter; ACCESS waits indefinitely; rsp_timeout tied 0.
// STRUCTURE
//  Shared package (bldc/types.sv): apb_master_state_t {idle, setup, access, resp};
//   peripheral register offsets (status 0x00, enc counter 0x04, rot duration 0x08) for bench/firmware.
//  No sub-module; the timeout counter stays inline under `ifdef.
// TESTING
//  1 Read 0x00 vs BLDC peripheral, hall=3'b101 -> SETUP then ACCESS, rsp_rdata[2:0]=3'b101, rsp_err=0.
//  2 Write 0x04 data 0xDEADBEEF strb 4'hF, pready after 3 wait cycles -> pwdata stable throughout,
//    penable high 4 cycles, rsp_valid one cycle after pready, rsp_err=0.
//  3 Read 0x08 with pslverr=1 at pready -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
//  4 cmd_addr=0x05 -> psel never asserted, rsp_err=1; next command 0x04 proceeds normally.
//  5 rsp_ready held low 10 cycles, cmd_valid held high -> cmd_ready=0, psel=0, rsp stable; then accepted.
//  6 APB_TIMEOUT_EN, timeout_cycles=16, pready stuck 0 -> abort after 16 ACCESS cycles, rsp_timeout=1;
//    preset pulsed during ACCESS -> psel=0 next edge, rsp_valid=0.

Source files
------------

// File: rtl/apb2_master_bridge_pkg.sv
// Shared types and constants for the APB2 requester bridge and the BLDC register map.
package apb2_master_bridge_pkg;

    // Bridge sequencing states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } apb_master_state_t;

    // BLDC peripheral register offsets (byte addresses, word aligned)
    localparam logic [7:0] REG_STATUS       = 8'h00;
    localparam logic [7:0] REG_ENC_COUNT    = 8'h04;
    localparam logic [7:0] REG_ROT_DURATION = 8'h08;

    // Normal, secure, data access
    localparam logic [2:0] PPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/apb2_master_bridge.sv
// APB2 requester: one command at a time in, one APB setup/access transfer out, one response back.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb2_master_bridge
    import apb2_master_bridge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [2:0]              pprot,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    // A zero timeout would abort every transfer before the completer is sampled
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    apb_master_state_t       r_state, w_next_state;
    logic                    r_cmd_ready, w_cmd_ready;
    logic                    r_psel, w_psel;
    logic                    r_penable, w_penable;
    logic                    r_pwrite, w_pwrite;
    logic [ADDR_WIDTH-1:0]   r_paddr, w_paddr;
    logic [DATA_WIDTH-1:0]   r_pwdata, w_pwdata;
    logic [STRB_W-1:0]       r_pstrb, w_pstrb;
    logic                    r_rsp_valid, w_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata, w_rsp_rdata;
    logic                    r_rsp_err, w_rsp_err;
`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic                    r_rsp_timeout, w_rsp_timeout;
    logic [CNT_W-1:0]        r_acc_cnt, w_acc_cnt;
`endif

    // State and all registered outputs
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state       <= S_IDLE;
            r_cmd_ready   <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
`ifdef APB_TIMEOUT_EN
            r_rsp_timeout <= 1'b0;
            r_acc_cnt     <= '0;
`endif
        end else begin
            r_state       <= w_next_state;
            r_cmd_ready   <= w_cmd_ready;
            r_psel        <= w_psel;
            r_penable     <= w_penable;
            r_pwrite      <= w_pwrite;
            r_paddr       <= w_paddr;
            r_pwdata      <= w_pwdata;
            r_pstrb       <= w_pstrb;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_rdata   <= w_rsp_rdata;
            r_rsp_err     <= w_rsp_err;
`ifdef APB_TIMEOUT_EN
            r_rsp_timeout <= w_rsp_timeout;
            r_acc_cnt     <= w_acc_cnt;
`endif
        end
    end

    // Next state and next values of the registered outputs
    always_comb begin
        w_next_state  = r_state;
        w_psel        = r_psel;
        w_penable     = r_penable;
        w_pwrite      = r_pwrite;
        w_paddr       = r_paddr;
        w_pwdata      = r_pwdata;
        w_pstrb       = r_pstrb;
        w_rsp_valid   = r_rsp_valid;
        w_rsp_rdata   = r_rsp_rdata;
        w_rsp_err     = r_rsp_err;
`ifdef APB_TIMEOUT_EN
        w_rsp_timeout = r_rsp_timeout;
        w_acc_cnt     = r_acc_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                // r_cmd_ready gates the handshake so the cycle right after reset accepts nothing
                if (cmd_valid && r_cmd_ready) begin
                    w_paddr  = cmd_addr;
                    w_pwrite = cmd_write;
                    w_pwdata = cmd_wdata;
                    w_pstrb  = cmd_write ? cmd_strb : '0;
                    if (cmd_addr[1:0] != 2'b00) begin
                        // Misaligned: answer with an error, never touch the bus
                        w_next_state  = S_RESP;
                        w_rsp_valid   = 1'b1;
                        w_rsp_err     = 1'b1;
                        w_rsp_rdata   = '0;
`ifdef APB_TIMEOUT_EN
                        w_rsp_timeout = 1'b0;
`endif
                    end else begin
                        w_next_state = S_SETUP;
                        w_psel       = 1'b1;
                        w_penable    = 1'b0;
`ifdef APB_TIMEOUT_EN
                        w_acc_cnt    = '0;
`endif
                    end
                end
            end
            S_SETUP: begin
                w_next_state = S_ACCESS;
                w_penable    = 1'b1;
            end
            S_ACCESS: begin
                if (pready) begin
                    w_next_state  = S_RESP;
                    w_psel        = 1'b0;
                    w_penable     = 1'b0;
                    w_rsp_valid   = 1'b1;
                    w_rsp_err     = pslverr;
                    w_rsp_rdata   = (!r_pwrite && !pslverr) ? prdata : '0;
`ifdef APB_TIMEOUT_EN
                    w_rsp_timeout = 1'b0;
                end else if (r_acc_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Completer never answered: abandon the transfer
                    w_next_state  = S_RESP;
                    w_psel        = 1'b0;
                    w_penable     = 1'b0;
                    w_rsp_valid   = 1'b1;
                    w_rsp_err     = 1'b1;
                    w_rsp_rdata   = '0;
                    w_rsp_timeout = 1'b1;
                end else begin
                    w_acc_cnt     = r_acc_cnt + CNT_W'(1);
`endif
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next_state = S_IDLE;
                    w_rsp_valid  = 1'b0;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        w_cmd_ready = (w_next_state == S_IDLE);
    end

    assign cmd_ready = r_cmd_ready;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign pstrb     = r_pstrb;
    assign pprot     = PPROT_DEFAULT;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
`ifdef APB_TIMEOUT_EN
    assign rsp_timeout = r_rsp_timeout;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb2_master_bridge.sv
// Directed self-checking bench for apb2_master_bridge; bus completer is driven by hand.
module tb_apb2_master_bridge;
    import apb2_master_bridge_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 16;

    logic          pclk = 1'b0;
    logic          preset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [2:0]    pprot;
    logic [DW-1:0] prdata;
    logic          pready, pslverr;

    int n_checks = 0;
    int n_errors = 0;

    apb2_master_bridge #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO)
    ) u_dut (
        .pclk       (pclk),
        .preset     (preset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_strb   (cmd_strb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pstrb      (pstrb),
        .pprot      (pprot),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Offer a command and return just after the edge that accepts it
    task automatic send_cmd(input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, input logic [SW-1:0] st);
        int waited = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_strb  = st;
        while (cmd_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        preset = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({psel, penable, pwrite, cmd_ready, rsp_valid, rsp_err, rsp_timeout} !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: psel/pen/pwr/cmd_rdy/rsp_v/err/to=%b required 0000000",
                     {psel, penable, pwrite, cmd_ready, rsp_valid, rsp_err, rsp_timeout});
        end
        n_checks++;
        if ({paddr, pwdata, pstrb, rsp_rdata, pprot} !== '0) begin
            n_errors++;
            $display("FAIL reset_data: paddr=%h pwdata=%h pstrb=%h rdata=%h pprot=%b required all 0",
                     paddr, pwdata, pstrb, rsp_rdata, pprot);
        end
        preset = 1'b0;
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    // Read of the status register, hall bits 3'b101; pready already high during SETUP
    task automatic test_read_status();
        pready = 1'b1;
        prdata = 32'h0000_0005;
        send_cmd(1'b0, REG_STATUS, 32'hFFFF_FFFF, 4'hF);
        n_checks++;
        if ({psel, penable, pwrite, cmd_ready} !== 4'b1000 || pstrb !== 4'h0 || paddr !== REG_STATUS) begin
            n_errors++;
            $display("FAIL read_setup: psel/pen/pwr/rdy=%b pstrb=%h paddr=%h required 1000 0 00",
                     {psel, penable, pwrite, cmd_ready}, pstrb, paddr);
        end
        tick();
        n_checks++;
        if ({psel, penable, rsp_valid} !== 3'b110) begin
            n_errors++;
            $display("FAIL read_access: psel/pen/rsp_v=%b required 110", {psel, penable, rsp_valid});
        end
        tick();
        pready = 1'b0;
        prdata = 32'hFFFF_FFFF;
        n_checks++;
        if ({rsp_valid, rsp_err, psel, penable, cmd_ready} !== 5'b10000 || rsp_rdata[2:0] !== 3'b101) begin
            n_errors++;
            $display("FAIL read_resp: v/err/psel/pen/rdy=%b rdata=%h required 10000 rdata[2:0]=101",
                     {rsp_valid, rsp_err, psel, penable, cmd_ready}, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            n_errors++;
            $display("FAIL read_done: rsp_v/rdy=%b required 01", {rsp_valid, cmd_ready});
        end
    endtask

    // Write with three wait states; address/data must hold through ACCESS
    task automatic test_write_wait();
        int pen_cycles = 0;
        int unstable = 0;
        prdata = 32'h1234_5678;
        send_cmd(1'b1, REG_ENC_COUNT, 32'hDEAD_BEEF, 4'hF);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (penable === 1'b1) pen_cycles++;
            if (pwdata !== 32'hDEAD_BEEF || paddr !== REG_ENC_COUNT || pstrb !== 4'hF ||
                pwrite !== 1'b1 || psel !== 1'b1 || rsp_valid !== 1'b0) unstable++;
            pready = (i == 3);
        end
        n_checks++;
        if (pen_cycles != 4 || unstable != 0) begin
            n_errors++;
            $display("FAIL write_access: penable_cycles=%0d unstable=%0d required 4 0",
                     pen_cycles, unstable);
        end
        tick();
        pready = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_err, psel, penable} !== 4'b1000 || rsp_rdata !== 32'h0) begin
            n_errors++;
            $display("FAIL write_resp: v/err/psel/pen=%b rdata=%h required 1000 00000000",
                     {rsp_valid, rsp_err, psel, penable}, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // Completer error; rsp_ready already high so the response retires in one cycle
    task automatic test_slverr();
        rsp_ready = 1'b1;
        send_cmd(1'b0, REG_ROT_DURATION, 32'h0, 4'hF);
        tick();
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'hAAAA_5555;
        tick();
        pready  = 1'b0;
        pslverr = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110 || rsp_rdata !== 32'h0) begin
            n_errors++;
            $display("FAIL slverr_resp: v/err/to=%b rdata=%h required 110 00000000",
                     {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
        end
        tick();
        rsp_ready = 1'b0;
        n_checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            n_errors++;
            $display("FAIL slverr_same_cycle: rsp_v/rdy=%b required 01", {rsp_valid, cmd_ready});
        end
    endtask

    // Misaligned address errors without a bus cycle; next command is normal
    task automatic test_misaligned();
        int psel_seen = 0;
        pready = 1'b1;
        prdata = 32'h0000_0077;
        send_cmd(1'b0, 8'h05, 32'h0, 4'h0);
        if (psel !== 1'b0) psel_seen++;
        n_checks++;
        if ({rsp_valid, rsp_err} !== 2'b11 || rsp_rdata !== 32'h0) begin
            n_errors++;
            $display("FAIL misalign_resp: v/err=%b rdata=%h required 11 00000000",
                     {rsp_valid, rsp_err}, rsp_rdata);
        end
        tick();
        if (psel !== 1'b0) psel_seen++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        if (psel !== 1'b0) psel_seen++;
        n_checks++;
        if (psel_seen != 0) begin
            n_errors++;
            $display("FAIL misalign_nobus: psel_cycles=%0d required 0", psel_seen);
        end
        send_cmd(1'b0, REG_ENC_COUNT, 32'h0, 4'h0);
        tick();
        tick();
        pready = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h0000_0077) begin
            n_errors++;
            $display("FAIL misalign_next: v/err=%b rdata=%h required 10 00000077",
                     {rsp_valid, rsp_err}, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // Held response blocks the next command; released, the pending command goes out
    task automatic test_back_to_back();
        int bad = 0;
        pready = 1'b1;
        prdata = 32'h0000_00C3;
        send_cmd(1'b0, REG_STATUS, 32'h0, 4'h0);
        tick();
        tick();
        pready = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = REG_ROT_DURATION;
        cmd_wdata = 32'h0000_0042;
        cmd_strb  = 4'h3;
        for (int i = 0; i < 10; i++) begin
            if (cmd_ready !== 1'b0 || psel !== 1'b0 || rsp_valid !== 1'b1 ||
                rsp_rdata !== 32'h0000_00C3 || rsp_err !== 1'b0) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL hold_resp: bad_cycles=%0d required 0", bad);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++;
        if ({rsp_valid, cmd_ready, psel} !== 3'b010) begin
            n_errors++;
            $display("FAIL hold_release: rsp_v/rdy/psel=%b required 010", {rsp_valid, cmd_ready, psel});
        end
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if ({psel, penable, pwrite} !== 3'b101 || paddr !== REG_ROT_DURATION ||
            pwdata !== 32'h0000_0042 || pstrb !== 4'h3) begin
            n_errors++;
            $display("FAIL pending_cmd: psel/pen/pwr=%b paddr=%h pwdata=%h pstrb=%h required 101 08 00000042 3",
                     {psel, penable, pwrite}, paddr, pwdata, pstrb);
        end
        tick();
        pready = 1'b1;
        tick();
        pready = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // Reset during ACCESS discards the transfer
    task automatic test_reset_mid();
        send_cmd(1'b0, REG_STATUS, 32'h0, 4'h0);
        tick();
        preset = 1'b1;
        tick();
        n_checks++;
        if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_mid: psel/pen/rsp_v/rdy=%b required 0000",
                     {psel, penable, rsp_valid, cmd_ready});
        end
        preset = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({psel, rsp_valid, cmd_ready} !== 3'b001) begin
            n_errors++;
            $display("FAIL reset_mid_after: psel/rsp_v/rdy=%b required 001", {psel, rsp_valid, cmd_ready});
        end
    endtask

`ifdef APB_TIMEOUT_EN
    // Stuck completer aborts after TO ACCESS cycles; pready on the expiry cycle still wins
    task automatic test_timeout();
        int pen_cycles = 0;
        send_cmd(1'b0, REG_ENC_COUNT, 32'h0, 4'h0);
        tick();
        while (penable === 1'b1 && pen_cycles < 40) begin
            pen_cycles++;
            tick();
        end
        n_checks++;
        if (pen_cycles != TO || {rsp_valid, rsp_err, rsp_timeout, psel} !== 4'b1110 ||
            rsp_rdata !== 32'h0) begin
            n_errors++;
            $display("FAIL timeout_abort: access_cycles=%0d v/err/to/psel=%b rdata=%h required %0d 1110 0",
                     pen_cycles, {rsp_valid, rsp_err, rsp_timeout, psel}, rsp_rdata, TO);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        send_cmd(1'b0, REG_ENC_COUNT, 32'h0, 4'h0);
        tick();
        for (int i = 0; i < int'(TO) - 1; i++) tick();
        pready = 1'b1;
        prdata = 32'h0000_0033;
        tick();
        pready = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100 || rsp_rdata !== 32'h0000_0033) begin
            n_errors++;
            $display("FAIL timeout_race: v/err/to=%b rdata=%h required 100 00000033",
                     {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        test_reset();
        test_read_status();
        test_write_wait();
        test_slverr();
        test_misaligned();
        test_back_to_back();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
